// File: rtl/sram_bus_responder.sv
// Device end of the async SRAM pin bus: synchronizes the strobes, stores words in
// internal block RAM and drives read data back with a tri-state enable.
module sram_bus_responder #(
    parameter int MEM_ADDR_BITS = 12,
    parameter int SYNC_STAGES   = 2,
    parameter int READ_LATENCY  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [17:0] sram_addr,
    input  logic [15:0] sram_data_in,
    input  logic        sram_wex,
    input  logic        sram_oex,
    input  logic        sram_csx,
    output logic [15:0] sram_data_out,
    output logic        sram_data_oe,
    output logic [15:0] write_count,
    output logic [15:0] read_count,
    output logic        conflict
);

    localparam int BUS_W = 18 + 16 + 3;
    localparam logic [BUS_W-1:0] BUS_IDLE = {34'd0, 3'b111};
    localparam int CNT_W = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(READ_LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ_WAIT,
        READ_DRIVE
    } state_t;

    state_t state_q, state_d;

    logic [BUS_W-1:0] sync_q [SYNC_STAGES];
    logic [BUS_W-1:0] sync_d [SYNC_STAGES];

    logic [17:0] addr_s;
    logic [15:0] data_s;
    logic        wex_s, oex_s, csx_s;
    logic        cs, we, oe;

    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [MEM_ADDR_BITS-1:0] pend_addr_q, pend_addr_d;
    logic [15:0]              pend_data_q, pend_data_d;
    logic [17:0]              addr_prev_q, addr_prev_d;
    logic [15:0]              write_count_q, write_count_d;
    logic [15:0]              read_count_q, read_count_d;
    logic                     conflict_q, conflict_d;

    logic [15:0]              mem [2**MEM_ADDR_BITS];
    logic [15:0]              rd_data_q;
    logic [MEM_ADDR_BITS-1:0] rd_idx;
    logic                     rd_bypass;
    logic                     commit;
    logic                     rd_done;

    // All bus pins share one pipeline so address, data and strobes stay aligned.
    always_comb begin
        sync_d[0] = {sram_addr, sram_data_in, sram_wex, sram_oex, sram_csx};
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= BUS_IDLE;
            end
        end else begin
            sync_q <= sync_d;
        end
    end

    always_comb begin
        {addr_s, data_s, wex_s, oex_s, csx_s} = sync_q[SYNC_STAGES-1];
        cs     = ~csx_s;
        we     = ~wex_s;
        oe     = ~oex_s;
        rd_idx = addr_s[MEM_ADDR_BITS-1:0];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cs && we) begin
                    state_d = WRITE;
                end else if (cs && oe) begin
                    state_d = READ_WAIT;
                    cnt_d   = LAT_LOAD;
                end
            end
            WRITE: begin
                if (!(cs && we)) begin
                    if (cs && oe) begin
                        state_d = READ_WAIT;
                        cnt_d   = LAT_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            READ_WAIT: begin
                if (cs && we) begin
                    state_d = WRITE;
                end else if (!(cs && oe)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = READ_DRIVE;
                    end
                end
            end
            READ_DRIVE: begin
                if (!(cs && oe)) begin
                    state_d = IDLE;
                end else if (we) begin
                    state_d = WRITE;
                end else if (addr_s != addr_prev_q) begin
                    state_d = READ_WAIT;
                    cnt_d   = LAT_LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        commit        = (state_q == WRITE) && !(cs && we);
        rd_done       = (state_q == READ_DRIVE) && !(cs && oe);
        rd_bypass     = commit && (pend_addr_q == rd_idx);
        pend_addr_d   = (cs && we) ? rd_idx : pend_addr_q;
        pend_data_d   = (cs && we) ? data_s : pend_data_q;
        addr_prev_d   = addr_s;
        write_count_d = write_count_q + (commit ? 16'd1 : 16'd0);
        read_count_d  = read_count_q + (rd_done ? 16'd1 : 16'd0);
        conflict_d    = conflict_q | (cs & we & oe);
        sram_data_oe  = (state_q == READ_DRIVE);
        sram_data_out = sram_data_oe ? rd_data_q : '0;
        write_count   = write_count_q;
        read_count    = read_count_q;
        conflict      = conflict_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_addr_q   <= '0;
            pend_data_q   <= '0;
            addr_prev_q   <= '0;
            write_count_q <= '0;
            read_count_q  <= '0;
            conflict_q    <= 1'b0;
        end else begin
            pend_addr_q   <= pend_addr_d;
            pend_data_q   <= pend_data_d;
            addr_prev_q   <= addr_prev_d;
            write_count_q <= write_count_d;
            read_count_q  <= read_count_d;
            conflict_q    <= conflict_d;
        end
    end

    // Block RAM with write-first bypass; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[pend_addr_q] <= pend_data_q;
        end
        rd_data_q <= rd_bypass ? pend_data_q : mem[rd_idx];
    end

endmodule

// File: tb/tb_sram_bus_responder.sv
// Directed bench for sram_bus_responder: table of write/read transactions plus
// hand-written sequences for address change, conflict and reset corners.
module tb_sram_bus_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [17:0] sram_addr = '0;
    logic [15:0] sram_data_in = '0;
    logic        sram_wex = 1'b1;
    logic        sram_oex = 1'b1;
    logic        sram_csx = 1'b1;
    logic [15:0] sram_data_out;
    logic        sram_data_oe;
    logic [15:0] write_count;
    logic [15:0] read_count;
    logic        conflict;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sram_bus_responder #(
        .MEM_ADDR_BITS(12),
        .SYNC_STAGES  (2),
        .READ_LATENCY (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sram_addr    (sram_addr),
        .sram_data_in (sram_data_in),
        .sram_wex     (sram_wex),
        .sram_oex     (sram_oex),
        .sram_csx     (sram_csx),
        .sram_data_out(sram_data_out),
        .sram_data_oe (sram_data_oe),
        .write_count  (write_count),
        .read_count   (read_count),
        .conflict     (conflict)
    );

    typedef struct {
        bit          wr;
        logic [17:0] addr;
        logic [15:0] data;
        logic [15:0] exp_wc;
        logic [15:0] exp_rc;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [17:0] addr, input logic [15:0] data,
                             input logic [15:0] exp_wc);
        logic oe_seen;
        oe_seen      = 1'b0;
        sram_addr    = addr;
        sram_data_in = data;
        sram_csx     = 1'b0;
        sram_wex     = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (sram_data_oe) oe_seen = 1'b1;
        end
        check("wr_pending_count", {16'd0, write_count}, {16'd0, exp_wc - 16'd1});
        sram_wex = 1'b1;
        sram_csx = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (sram_data_oe) oe_seen = 1'b1;
        end
        check("wr_oe_low", {31'd0, oe_seen}, 32'd0);
        check("wr_count", {16'd0, write_count}, {16'd0, exp_wc});
    endtask

    task automatic bus_read(input logic [17:0] addr, input logic [15:0] exp,
                            input logic [15:0] exp_rc);
        sram_addr = addr;
        sram_csx  = 1'b0;
        sram_oex  = 1'b0;
        step(4);
        check("rd_oe_edge4", {31'd0, sram_data_oe}, 32'd0);
        step(1);
        check("rd_oe_edge5", {31'd0, sram_data_oe}, 32'd1);
        check("rd_data", {16'd0, sram_data_out}, {16'd0, exp});
        sram_csx = 1'b1;
        sram_oex = 1'b1;
        step(2);
        check("rd_oe_hold", {31'd0, sram_data_oe}, 32'd1);
        step(1);
        check("rd_oe_release", {31'd0, sram_data_oe}, 32'd0);
        check("rd_count", {16'd0, read_count}, {16'd0, exp_rc});
    endtask

    initial begin
        logic oe_seen;
        logic exp_oe [5];

        vecs[0]  = '{1'b1, 18'h00010, 16'hBEEF, 16'd1, 16'd0};
        vecs[1]  = '{1'b0, 18'h00010, 16'hBEEF, 16'd1, 16'd1};
        vecs[2]  = '{1'b1, 18'h01005, 16'h1234, 16'd2, 16'd1};
        vecs[3]  = '{1'b0, 18'h00005, 16'h1234, 16'd2, 16'd2};
        vecs[4]  = '{1'b1, 18'h00003, 16'hAAAA, 16'd3, 16'd2};
        vecs[5]  = '{1'b1, 18'h00004, 16'h5555, 16'd4, 16'd2};
        vecs[6]  = '{1'b0, 18'h00003, 16'hAAAA, 16'd4, 16'd3};
        vecs[7]  = '{1'b1, 18'h3FFFF, 16'hA5C3, 16'd5, 16'd3};
        vecs[8]  = '{1'b0, 18'h00FFF, 16'hA5C3, 16'd5, 16'd4};
        vecs[9]  = '{1'b1, 18'h00010, 16'h1111, 16'd6, 16'd4};
        vecs[10] = '{1'b0, 18'h2F010, 16'h1111, 16'd6, 16'd5};

        // Reset held with strobes toggling
        for (int i = 0; i < 6; i++) begin
            sram_csx = i[0];
            sram_wex = i[1];
            sram_oex = i[0];
            step(1);
        end
        check("rst_oe", {31'd0, sram_data_oe}, 32'd0);
        check("rst_dout", {16'd0, sram_data_out}, 32'd0);
        check("rst_wc", {16'd0, write_count}, 32'd0);
        check("rst_rc", {16'd0, read_count}, 32'd0);
        check("rst_conflict", {31'd0, conflict}, 32'd0);
        sram_csx = 1'b1;
        sram_wex = 1'b1;
        sram_oex = 1'b0;
        rst_n    = 1'b1;
        oe_seen  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (sram_data_oe) oe_seen = 1'b1;
        end
        sram_oex = 1'b1;
        check("post_rst_oe_csx_high", {31'd0, oe_seen}, 32'd0);

        for (int v = 0; v < 11; v++) begin
            if (vecs[v].wr) bus_write(vecs[v].addr, vecs[v].data, vecs[v].exp_wc);
            else            bus_read(vecs[v].addr, vecs[v].data, vecs[v].exp_rc);
        end

        // Address change while driving
        sram_addr = 18'h00003;
        sram_csx  = 1'b0;
        sram_oex  = 1'b0;
        step(5);
        check("achg_first_oe", {31'd0, sram_data_oe}, 32'd1);
        check("achg_first_data", {16'd0, sram_data_out}, 32'h0000AAAA);
        sram_addr = 18'h00004;
        exp_oe = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            step(1);
            check($sformatf("achg_oe_step%0d", i + 1), {31'd0, sram_data_oe}, {31'd0, exp_oe[i]});
        end
        check("achg_new_data", {16'd0, sram_data_out}, 32'h00005555);
        sram_csx = 1'b1;
        sram_oex = 1'b1;
        step(3);
        check("achg_rc", {16'd0, read_count}, 32'd6);

        // WE and OE low together under CS
        sram_addr    = 18'h00020;
        sram_data_in = 16'h0F0F;
        sram_csx     = 1'b0;
        sram_wex     = 1'b0;
        sram_oex     = 1'b0;
        oe_seen      = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (sram_data_oe) oe_seen = 1'b1;
        end
        check("conf_flag", {31'd0, conflict}, 32'd1);
        sram_csx = 1'b1;
        sram_wex = 1'b1;
        sram_oex = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (sram_data_oe) oe_seen = 1'b1;
        end
        check("conf_oe_never", {31'd0, oe_seen}, 32'd0);
        check("conf_wc", {16'd0, write_count}, 32'd7);
        bus_read(18'h00020, 16'h0F0F, 16'd7);
        check("conf_sticky", {31'd0, conflict}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("conf_cleared", {31'd0, conflict}, 32'd0);
        check("rst_pulse_wc", {16'd0, write_count}, 32'd0);
        check("rst_pulse_rc", {16'd0, read_count}, 32'd0);
        step(1);
        rst_n = 1'b1;
        step(2);

        // Reset during a pending write
        bus_write(18'h00007, 16'h7777, 16'd1);
        sram_addr    = 18'h00007;
        sram_data_in = 16'hDEAD;
        sram_csx     = 1'b0;
        sram_wex     = 1'b0;
        step(5);
        check("mwr_pending", {16'd0, write_count}, 32'd1);
        rst_n    = 1'b0;
        sram_csx = 1'b1;
        sram_wex = 1'b1;
        step(2);
        rst_n = 1'b1;
        step(4);
        check("mwr_wc", {16'd0, write_count}, 32'd0);
        bus_read(18'h00007, 16'h7777, 16'd1);

        // Reset while driving read data
        sram_addr = 18'h00007;
        sram_csx  = 1'b0;
        sram_oex  = 1'b0;
        step(5);
        check("mrd_oe", {31'd0, sram_data_oe}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mrd_oe_async", {31'd0, sram_data_oe}, 32'd0);
        check("mrd_dout_async", {16'd0, sram_data_out}, 32'd0);
        sram_csx = 1'b1;
        sram_oex = 1'b1;
        step(2);
        rst_n = 1'b1;
        step(3);
        check("mrd_oe_after", {31'd0, sram_data_oe}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
